// File: rtl/pu_intdispatch_pkg.sv
// Shared definitions for the interrupt dispatcher: pi1 op codes, register
// offsets and the offer FSM state type.
package pu_intdispatch_pkg;

    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [1:0] PIWROP = 2'd1;
    localparam logic [1:0] PIRDOP = 2'd2;
    localparam logic [1:0] PIRWOP = 2'd3;

    localparam logic [1:0] INTD_CLAIM = 2'd0;
    localparam logic [1:0] INTD_ACK   = 2'd1;
    localparam logic [1:0] INTD_PEND  = 2'd2;
    localparam logic [1:0] INTD_EN    = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } intd_state_t;

    // Returns {reads, writes} for a pi1 op code.
    function automatic logic [1:0] pi1_decode(input logic [1:0] op);
        case (op)
            PINOOP: return 2'b00;
            PIWROP: return 2'b01;
            PIRDOP: return 2'b10;
            PIRWOP: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/pu_intdispatch_rrarb.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping,
// returned as a one-hot grant and its index.
module pu_intdispatch_rrarb #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          vld
);

    int j;

    // Scan from farthest to nearest so the nearest request wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = PW'(j);
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pu_intdispatch.sv
// Interrupt dispatcher: offers level sources to ready PUs one at a time and
// exposes claim/ack/pending/enable registers on a pi1 slave port.
module pu_intdispatch
    import pu_intdispatch_pkg::*;
#(
    parameter int PUCOUNT   = 2,
    parameter int SRCCOUNT  = 8,
    parameter int ARCHBITSZ = 32,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    input  logic [SRCCOUNT-1:0]    src_i,
    output logic [SRCCOUNT-1:0]    src_ack_o,
    output logic [PUCOUNT-1:0]     intrqst_o,
    input  logic [PUCOUNT-1:0]     intrdy_i
);

    localparam int PW = (PUCOUNT > 1) ? $clog2(PUCOUNT) : 1;
    localparam int SW = $clog2(SRCCOUNT);

    intd_state_t                  state;
    logic [PUCOUNT-1:0]           busy;
    logic [PUCOUNT-1:0][SW-1:0]   owner;
    logic [SRCCOUNT-1:0]          insvc;
    logic [SRCCOUNT-1:0]          enable;
    logic [PW-1:0]                rr;
    logic [PW-1:0]                cur_pu;
    logic [PUCOUNT-1:0]           cur_gnt;
    logic [SW-1:0]                cur_src;

    logic [SRCCOUNT-1:0]          src_elig;
    logic [SW-1:0]                src_idx;
    logic                         src_any;
    logic [PUCOUNT-1:0]           pu_gnt;
    logic [PW-1:0]                pu_idx;
    logic                         pu_any;

    logic [1:0]                   op_dec;
    logic                         op_wr;
    logic                         op_rd;
    logic [1:0]                   reg_sel;
    logic [ARCHBITSZ-1:0]         claim_val;
    logic [ARCHBITSZ-1:0]         rdata;
    logic [SRCCOUNT-1:0]          ack_hit;
    logic [PUCOUNT-1:0]           busy_clr;
    logic                         unused_ok;

    assign unused_ok = &{1'b0, pi1_sel_i, pi1_addr_i[ADDRBITSZ-1:2]};

    assign src_elig = src_i & enable & ~insvc;
    assign src_any  = |src_elig;

    always_comb begin
        src_idx = '0;
        for (int i = SRCCOUNT - 1; i >= 0; i--)
            if (src_elig[i]) src_idx = SW'(i);
    end

    pu_intdispatch_rrarb #(.N(PUCOUNT)) u_rrarb (
        .req (intrdy_i & ~busy),
        .ptr (rr),
        .gnt (pu_gnt),
        .idx (pu_idx),
        .vld (pu_any)
    );

    assign op_dec  = pi1_decode(pi1_op_i);
    assign op_wr   = pi1_rdy_o & op_dec[0];
    assign op_rd   = pi1_rdy_o & op_dec[1];
    assign reg_sel = pi1_addr_i[1:0];

    // Indices are matched against the full data word so high bits never alias.
    always_comb begin
        claim_val = '1;
        for (int i = 0; i < PUCOUNT; i++)
            if (pi1_data_i == ARCHBITSZ'(i) && busy[i]) claim_val = ARCHBITSZ'(owner[i]);
    end

    always_comb begin
        ack_hit = '0;
        for (int i = 0; i < SRCCOUNT; i++)
            ack_hit[i] = op_wr && (reg_sel == INTD_ACK) &&
                         (pi1_data_i == ARCHBITSZ'(i)) && insvc[i];
    end

    always_comb begin
        for (int j = 0; j < PUCOUNT; j++)
            busy_clr[j] = busy[j] && ack_hit[owner[j]];
    end

    always_comb begin
        case (reg_sel)
            INTD_CLAIM: rdata = claim_val;
            INTD_ACK:   rdata = '0;
            INTD_PEND:  rdata = ARCHBITSZ'(src_i & enable);
            default:    rdata = ARCHBITSZ'(enable);
        endcase
    end

    // Offer FSM plus service bookkeeping; acceptance bits are written after
    // the ack clears so both land when they hit different PUs/sources.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            intrqst_o <= '0;
            busy      <= '0;
            owner     <= '0;
            insvc     <= '0;
            rr        <= '0;
            cur_pu    <= '0;
            cur_gnt   <= '0;
            cur_src   <= '0;
        end else begin
            busy  <= busy & ~busy_clr;
            insvc <= insvc & ~ack_hit;
            case (state)
                ST_IDLE: begin
                    intrqst_o <= '0;
                    if (src_any && pu_any) begin
                        cur_src <= src_idx;
                        cur_pu  <= pu_idx;
                        cur_gnt <= pu_gnt;
                        state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (!(src_i[cur_src] && enable[cur_src])) begin
                        intrqst_o <= '0;
                        state     <= ST_IDLE;
                    end else if (|(intrqst_o & intrdy_i & cur_gnt)) begin
                        intrqst_o      <= '0;
                        busy[cur_pu]   <= 1'b1;
                        owner[cur_pu]  <= cur_src;
                        insvc[cur_src] <= 1'b1;
                        rr             <= (cur_pu == PW'(PUCOUNT - 1)) ? '0 : cur_pu + 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        intrqst_o <= cur_gnt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pi1_rdy_o  <= 1'b0;
            pi1_data_o <= '0;
            src_ack_o  <= '0;
            enable     <= '1;
        end else begin
            pi1_rdy_o  <= 1'b1;
            src_ack_o  <= ack_hit;
            pi1_data_o <= op_rd ? rdata : '0;
            if (op_wr && reg_sel == INTD_EN) enable <= SRCCOUNT'(pi1_data_i);
        end
    end

endmodule
